multi_cycle_ctrl: RTL and testbench
===================================

MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 16: maximum number of cycles to wait for MemReady in a memory state before faulting.
REQ-002 Clock  in  1  sole clock; all state updates on the rising edge.
REQ-003 Reset  in  1  synchronous, active-high reset.
REQ-004 Opcode  in  6  IR[31:26]; Funct  in  6  IR[5:0]; both sampled from the instruction register.
REQ-005 Zero  in  1  ALU zero flag; MemReady  in  1  data-memory access complete.
REQ-006 PCEn  out  1  PC load; PCSrc  out  2  PC source: 00 = ALU, 01 = ALUOut (branch), 10 = jump target.
REQ-007 IRWrite, RegWrite, RegDst, MemToReg, MemRead, MemWrite, ALUSrcA  out  1 each: datapath strobes and mux selects.
REQ-008 ALUSrcB  out  2  ALU operand B select: 00 = B, 01 = const 4, 10 = sign-extended immediate, 11 = immediate shifted left 2.
REQ-009 ALUCtrl  out  3  ALU operation: 010 = add, 110 = sub, 000 = and, 001 = or, 111 = slt.
REQ-010 Halt  out  1  sticky fault flag; FaultCode  out  2  fault cause: 01 = illegal opcode, 10 = memory timeout.
REQ-011 InstCount  out  32  count of retired instructions.

Function
REQ-012 Moore FSM; all outputs except PCEn are decoded from the registered state only.
REQ-013 PCEn = PCWrite(state) OR (state == BRANCH AND Zero).
REQ-014 States: IDLE, FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR, WB_R, WB_MEM, BRANCH, JUMP, HALT.
REQ-015 IDLE -> FETCH unconditionally; IDLE drives every output 0.
REQ-016 FETCH: MemRead = 1, IRWrite = 1, ALUSrcA = 0, ALUSrcB = 01, ALUCtrl = add, PCWrite = 1, PCSrc = 00; next state DECODE.
REQ-017 DECODE: ALUSrcA = 0, ALUSrcB = 11, ALUCtrl = add (branch target precompute); next state by Opcode:
  000000 -> EXEC_R; 001000 (addi) -> EXEC_I; 100011 (lw) -> MEM_ADDR; 101011 (sw) -> MEM_ADDR; 000100 (beq) -> BRANCH; 000010 (j) -> JUMP; any other opcode -> HALT with FaultCode = 01.
REQ-018 EXEC_R: ALUSrcA = 1, ALUSrcB = 00; Funct 100000/100010/100100/100101/101010 select add/sub/and/or/slt; any other Funct -> HALT with FaultCode = 01; otherwise next state WB_R.
REQ-019 WB_R: RegWrite = 1, RegDst = 1, MemToReg = 0; retires; next state FETCH.
REQ-020 EXEC_I: ALUSrcA = 1, ALUSrcB = 10, ALUCtrl = add; next state WB_MEM with MemToReg = 0 and RegDst = 0 (addi write-back).
REQ-021 MEM_ADDR: ALUSrcA = 1, ALUSrcB = 10, ALUCtrl = add; next state MEM_RD for lw, MEM_WR for sw.
REQ-022 MEM_RD/MEM_WR: hold MemRead/MemWrite asserted until MemReady = 1; MEM_RD -> WB_MEM; MEM_WR retires -> FETCH.
REQ-023 WB_MEM (lw): RegWrite = 1, RegDst = 0, MemToReg = 1; retires; next state FETCH.
REQ-024 Wait counter clears on entry to MEM_RD/MEM_WR; if MemReady is still 0 after MEM_TIMEOUT cycles in the state -> HALT with FaultCode = 10.
REQ-025 BRANCH: ALUSrcA = 1, ALUSrcB = 00, ALUCtrl = sub, PCSrc = 01; retires; next state FETCH.
REQ-026 JUMP: PCWrite = 1, PCSrc = 10; retires; next state FETCH.
REQ-027 Latency in cycles with MemReady immediate: R/addi 4, lw 5, sw 4, beq 3, j 3; each wait cycle in a memory state adds 1.
REQ-028 HALT: all strobes 0, Halt = 1; state is absorbing until Reset.
REQ-029 InstCount increments by 1 on the final cycle of each retired instruction; wraps from 0xFFFFFFFF to 0; faulted instructions do not count.

Reset
REQ-030 Reset = 1 at a rising edge -> state IDLE, InstCount = 0, wait counter = 0, Halt = 0, FaultCode = 00, all strobes 0, from any state including mid-memory-wait.
REQ-031 Reset has priority over every transition and over InstCount increment.

Structure
REQ-032 A shared package holds the state encoding, the opcode and funct constants, and the ALUCtrl codes.
REQ-033 The ALU-control decode (state + Funct -> ALUCtrl) is one sub-module, alu_ctrl_dec.

Verification
REQ-034 Reset, then add (Opcode 000000, Funct 100000) -> IRWrite in cycle 2, RegWrite = 1 and RegDst = 1 in cycle 5, InstCount = 1.
REQ-035 lw with MemReady delayed 3 cycles -> MemRead held for 4 cycles in MEM_RD, then WB_MEM with MemToReg = 1; total 8 cycles.
REQ-036 beq with Zero = 1 -> PCEn = 1 and PCSrc = 01 in BRANCH; beq with Zero = 0 -> PCEn = 0; both increment InstCount.
REQ-037 Opcode 111111 -> Halt = 1, FaultCode = 01, InstCount unchanged, state stays HALT for 20 cycles.
REQ-038 sw with MemReady held at 0 -> Halt with FaultCode = 10 after 16 wait cycles; Reset asserted mid-wait -> IDLE, then FETCH.

Source files
------------

// File: rtl/multi_cycle_ctrl_pkg.sv
// Shared definitions for the multi-cycle controller: state encoding, ISA field constants, ALU codes.
package multi_cycle_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_EXEC_I,
        S_MEM_ADDR,
        S_MEM_RD,
        S_MEM_WR,
        S_WB_R,
        S_WB_MEM,
        S_BRANCH,
        S_JUMP,
        S_HALT
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] FAULT_NONE    = 2'b00;
    localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
    localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

    // Returns {legal, alu_code}; unknown functs map to {0, ALU_AND}.
    function automatic logic [3:0] funct_to_alu(input logic [5:0] funct);
        case (funct)
            FN_ADD:  return {1'b1, ALU_ADD};
            FN_SUB:  return {1'b1, ALU_SUB};
            FN_AND:  return {1'b1, ALU_AND};
            FN_OR:   return {1'b1, ALU_OR};
            FN_SLT:  return {1'b1, ALU_SLT};
            default: return {1'b0, ALU_AND};
        endcase
    endfunction

endpackage

// File: rtl/alu_ctrl_dec.sv
// ALU operation select from the controller state, with the Funct field consulted only in EXEC_R.
module alu_ctrl_dec
    import multi_cycle_ctrl_pkg::*;
(
    input  state_t      state,
    input  logic [5:0]  funct,
    output logic [2:0]  alu_ctrl,
    output logic        funct_ok
);

    logic [3:0] funct_dec;

    always_comb begin
        funct_dec = funct_to_alu(funct);
        funct_ok  = funct_dec[3];
        alu_ctrl  = ALU_AND;
        case (state)
            S_FETCH, S_DECODE, S_EXEC_I, S_MEM_ADDR: alu_ctrl = ALU_ADD;
            S_BRANCH:                                alu_ctrl = ALU_SUB;
            S_EXEC_R:                                alu_ctrl = funct_dec[2:0];
            default:                                 alu_ctrl = ALU_AND;
        endcase
    end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Moore control FSM for a multi-cycle MIPS-style datapath with memory-wait timeout and fault halt.
module multi_cycle_ctrl
    import multi_cycle_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [5:0]  Opcode,
    input  logic [5:0]  Funct,
    input  logic        Zero,
    input  logic        MemReady,
    output logic        PCEn,
    output logic [1:0]  PCSrc,
    output logic        IRWrite,
    output logic        RegWrite,
    output logic        RegDst,
    output logic        MemToReg,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [2:0]  ALUCtrl,
    output logic        Halt,
    output logic [1:0]  FaultCode,
    output logic [31:0] InstCount
);

    localparam int WW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(MEM_TIMEOUT - 1);

    state_t         state_reg;
    logic [WW-1:0]  wait_reg;
    logic           is_load_reg;
    logic [1:0]     fault_reg;
    logic [31:0]    count_reg;
    logic [2:0]     alu_ctrl;
    logic           funct_ok;
    logic           pc_write;

    alu_ctrl_dec u_alu_ctrl_dec (
        .state    (state_reg),
        .funct    (Funct),
        .alu_ctrl (alu_ctrl),
        .funct_ok (funct_ok)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_reg   <= S_IDLE;
            wait_reg    <= '0;
            is_load_reg <= 1'b0;
            fault_reg   <= FAULT_NONE;
            count_reg   <= '0;
        end else begin
            case (state_reg)
                S_IDLE:  state_reg <= S_FETCH;
                S_FETCH: state_reg <= S_DECODE;
                S_DECODE: begin
                    // Remember lw vs sw so WB_MEM and MEM_ADDR never look back at the IR.
                    is_load_reg <= (Opcode == OP_LW);
                    case (Opcode)
                        OP_RTYPE:     state_reg <= S_EXEC_R;
                        OP_ADDI:      state_reg <= S_EXEC_I;
                        OP_LW, OP_SW: state_reg <= S_MEM_ADDR;
                        OP_BEQ:       state_reg <= S_BRANCH;
                        OP_J:         state_reg <= S_JUMP;
                        default: begin
                            state_reg <= S_HALT;
                            fault_reg <= FAULT_ILLEGAL;
                        end
                    endcase
                end
                S_EXEC_R: begin
                    if (funct_ok) begin
                        state_reg <= S_WB_R;
                    end else begin
                        state_reg <= S_HALT;
                        fault_reg <= FAULT_ILLEGAL;
                    end
                end
                S_EXEC_I: state_reg <= S_WB_MEM;
                S_MEM_ADDR: begin
                    wait_reg  <= '0;
                    state_reg <= is_load_reg ? S_MEM_RD : S_MEM_WR;
                end
                S_MEM_RD, S_MEM_WR: begin
                    if (MemReady) begin
                        if (state_reg == S_MEM_RD) begin
                            state_reg <= S_WB_MEM;
                        end else begin
                            state_reg <= S_FETCH;
                            count_reg <= count_reg + 32'd1;
                        end
                    end else if (wait_reg == WAIT_LAST) begin
                        state_reg <= S_HALT;
                        fault_reg <= FAULT_TIMEOUT;
                    end else begin
                        wait_reg <= wait_reg + WW'(1);
                    end
                end
                S_WB_R, S_WB_MEM, S_BRANCH, S_JUMP: begin
                    state_reg <= S_FETCH;
                    count_reg <= count_reg + 32'd1;
                end
                S_HALT:  state_reg <= S_HALT;
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        pc_write = 1'b0;
        PCSrc    = 2'b00;
        IRWrite  = 1'b0;
        RegWrite = 1'b0;
        RegDst   = 1'b0;
        MemToReg = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        ALUSrcA  = 1'b0;
        ALUSrcB  = 2'b00;
        case (state_reg)
            S_FETCH: begin
                MemRead  = 1'b1;
                IRWrite  = 1'b1;
                ALUSrcB  = 2'b01;
                pc_write = 1'b1;
            end
            S_DECODE:               ALUSrcB = 2'b11;
            S_EXEC_R:               ALUSrcA = 1'b1;
            S_EXEC_I, S_MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEM_RD:               MemRead = 1'b1;
            S_MEM_WR:               MemWrite = 1'b1;
            S_WB_R: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            S_WB_MEM: begin
                RegWrite = 1'b1;
                MemToReg = is_load_reg;
            end
            S_BRANCH: begin
                ALUSrcA = 1'b1;
                PCSrc   = 2'b01;
            end
            S_JUMP: begin
                pc_write = 1'b1;
                PCSrc    = 2'b10;
            end
            default: ;
        endcase
    end

    assign PCEn      = pc_write | ((state_reg == S_BRANCH) & Zero);
    assign ALUCtrl   = alu_ctrl;
    assign Halt      = (state_reg == S_HALT);
    assign FaultCode = fault_reg;
    assign InstCount = count_reg;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Bench for multi_cycle_ctrl: directed and random instructions against a per-instruction cycle model.
module tb_multi_cycle_ctrl;

    localparam int TIMEOUT = 16;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic [5:0]  Opcode = '0;
    logic [5:0]  Funct = '0;
    logic        Zero = 1'b0;
    logic        MemReady = 1'b0;
    logic        PCEn;
    logic [1:0]  PCSrc;
    logic        IRWrite, RegWrite, RegDst, MemToReg, MemRead, MemWrite, ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [2:0]  ALUCtrl;
    logic        Halt;
    logic [1:0]  FaultCode;
    logic [31:0] InstCount;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] model_count = 0;
    logic [17:0] obs;

    always #5 Clock = ~Clock;

    multi_cycle_ctrl #(.MEM_TIMEOUT(TIMEOUT)) dut (
        .Clock(Clock), .Reset(Reset), .Opcode(Opcode), .Funct(Funct),
        .Zero(Zero), .MemReady(MemReady), .PCEn(PCEn), .PCSrc(PCSrc),
        .IRWrite(IRWrite), .RegWrite(RegWrite), .RegDst(RegDst),
        .MemToReg(MemToReg), .MemRead(MemRead), .MemWrite(MemWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUCtrl(ALUCtrl),
        .Halt(Halt), .FaultCode(FaultCode), .InstCount(InstCount)
    );

    assign obs = {PCEn, PCSrc, IRWrite, RegWrite, RegDst, MemToReg, MemRead,
                  MemWrite, ALUSrcA, ALUSrcB, ALUCtrl, Halt, FaultCode};

    function automatic logic [17:0] w(input logic pcen, input logic [1:0] pcsrc,
                                      input logic irw, regw, regdst, m2r, mrd, mwr, srca,
                                      input logic [1:0] srcb, input logic [2:0] alu,
                                      input logic halt, input logic [1:0] fc);
        return {pcen, pcsrc, irw, regw, regdst, m2r, mrd, mwr, srca, srcb, alu, halt, fc};
    endfunction

    // Reference ALU selection for R-type; -1 marks an unsupported funct.
    function automatic int ref_alu(input logic [5:0] fn);
        case (fn)
            6'h20:   return 2;
            6'h22:   return 6;
            6'h24:   return 0;
            6'h25:   return 1;
            6'h2A:   return 7;
            default: return -1;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        vectors++;
        assert (o === e) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, o, e);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic halt_check(input string tag, input logic [1:0] fc, input int n);
        for (int i = 0; i < n; i++) begin
            Opcode   = 6'($urandom);
            MemReady = 1'($urandom);
            Zero     = 1'($urandom);
            chk($sformatf("%s halt%0d", tag, i), {14'b0, obs}, {14'b0, w(0,0,0,0,0,0,0,0,0,0,0,1,fc)});
            chk($sformatf("%s halt_cnt%0d", tag, i), InstCount, model_count);
            step();
        end
    endtask

    // Leaves the DUT in FETCH, with IDLE and the cleared counter checked on the way.
    task automatic do_reset();
        Reset  = 1'b1;
        Opcode = 6'($urandom);
        step();
        Reset = 1'b0;
        model_count = 0;
        chk("rst idle", {14'b0, obs}, 32'd0);
        chk("rst cnt", InstCount, 32'd0);
        step();
    endtask

    task automatic run(input string tag, input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input int delay, input int cut);
        logic [17:0] q[$];
        int mem_first;
        int alu;
        bit retire;
        bit fault;
        logic [1:0] fc;
        q = {};
        mem_first = -1;
        retire = 0;
        fault = 0;
        fc = 2'b00;
        q.push_back(w(1,2'b00,1,0,0,0,1,0,0,2'b01,3'b010,0,0));
        q.push_back(w(0,2'b00,0,0,0,0,0,0,0,2'b11,3'b010,0,0));
        alu = ref_alu(fn);
        if (op == 6'h00) begin
            q.push_back(w(0,0,0,0,0,0,0,0,1,2'b00, (alu < 0) ? 3'b000 : 3'(alu), 0, 0));
            if (alu >= 0) begin
                q.push_back(w(0,0,0,1,1,0,0,0,0,0,0,0,0));
                retire = 1;
            end else begin
                fault = 1;
                fc = 2'b01;
            end
        end else if (op == 6'h08) begin
            q.push_back(w(0,0,0,0,0,0,0,0,1,2'b10,3'b010,0,0));
            q.push_back(w(0,0,0,1,0,0,0,0,0,0,0,0,0));
            retire = 1;
        end else if (op == 6'h23 || op == 6'h2B) begin
            q.push_back(w(0,0,0,0,0,0,0,0,1,2'b10,3'b010,0,0));
            mem_first = q.size();
            for (int k = 0; k < ((delay < TIMEOUT) ? delay + 1 : TIMEOUT); k++)
                q.push_back((op == 6'h23) ? w(0,0,0,0,0,0,1,0,0,0,0,0,0)
                                          : w(0,0,0,0,0,0,0,1,0,0,0,0,0));
            if (delay < TIMEOUT) begin
                if (op == 6'h23) q.push_back(w(0,0,0,1,0,1,0,0,0,0,0,0,0));
                retire = 1;
            end else begin
                fault = 1;
                fc = 2'b10;
            end
        end else if (op == 6'h04) begin
            q.push_back(w(z,2'b01,0,0,0,0,0,0,1,2'b00,3'b110,0,0));
            retire = 1;
        end else if (op == 6'h02) begin
            q.push_back(w(1,2'b10,0,0,0,0,0,0,0,0,0,0,0));
            retire = 1;
        end else begin
            fault = 1;
            fc = 2'b01;
        end

        Opcode = op;
        Funct  = fn;
        for (int i = 0; i < q.size(); i++) begin
            if (cut >= 0 && i == cut) return;
            Zero = (op == 6'h04) ? z : 1'($urandom);
            if (mem_first >= 0 && i >= mem_first) MemReady = ((i - mem_first) == delay);
            else                                  MemReady = 1'($urandom);
            chk($sformatf("%s cyc%0d", tag, i), {14'b0, obs}, {14'b0, q[i]});
            step();
        end
        if (retire) begin
            model_count = model_count + 1;
            chk({tag, " count"}, InstCount, model_count);
        end
        if (fault) halt_check(tag, fc, 20);
    endtask

    logic [5:0] ops[6];
    logic [5:0] fns[5];

    initial begin
        ops = '{6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h02};
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
        step();
        do_reset();

        run("add", 6'h00, 6'h20, 1'b0, 0, -1);
        run("lw_d3", 6'h23, 6'h11, 1'b0, 3, -1);
        run("beq_z1", 6'h04, 6'h00, 1'b1, 0, -1);
        run("beq_z0", 6'h04, 6'h3F, 1'b0, 0, -1);
        run("sw_d0", 6'h2B, 6'h00, 1'b0, 0, -1);
        run("addi", 6'h08, 6'h15, 1'b0, 0, -1);
        run("j", 6'h02, 6'h00, 1'b0, 0, -1);
        run("sw_d15", 6'h2B, 6'h00, 1'b0, 15, -1);

        for (int n = 0; n < 40; n++) begin
            run($sformatf("rnd%0d", n), ops[$urandom_range(0, 5)], fns[$urandom_range(0, 4)],
                1'($urandom), int'($urandom_range(0, 4)), -1);
        end

        run("bad_op", 6'h3F, 6'h20, 1'b0, 0, -1);
        do_reset();
        run("bad_fn", 6'h00, 6'h3F, 1'b0, 0, -1);
        do_reset();
        run("addi2", 6'h08, 6'h00, 1'b0, 0, -1);
        run("sw_to", 6'h2B, 6'h00, 1'b0, 100, -1);
        do_reset();
        run("lw_to", 6'h23, 6'h00, 1'b0, 100, -1);
        do_reset();
        run("sw_cut", 6'h2B, 6'h00, 1'b0, 100, 8);
        do_reset();
        run("add_after", 6'h00, 6'h22, 1'b0, 0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
